// File: rtl/servo_pwm_decoder.sv
//------------------------------------------------------------------------------
// Module   : servo_pwm_decoder
// Brief    : Measures high time and rise-to-rise period of a servo PWM input.
//            Flags out-of-range periods and loss of signal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module servo_pwm_decoder #(
  parameter int CNT_W      = 32,
  parameter int MIN_WIDTH  = 40000,
  parameter int MAX_WIDTH  = 260000,
  parameter int MIN_PERIOD = 1800000,
  parameter int MAX_PERIOD = 2200000,
  parameter int TIMEOUT    = 3000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             err,
  output logic             lost
);

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_min_width    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] c_max_width    = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] c_min_period   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] c_max_period   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] c_timeout      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic [CNT_W-1:0] w_icnt_nxt;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_timeout;
  logic             w_check;
  logic             w_pass;

  // Two-flop synchronizer followed by a one-flop edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pwm_in};
      r_prev <= r_sync[1];
    end
  end

  assign w_rise = r_sync[1] & ~r_prev;
  assign w_fall = ~r_sync[1] & r_prev;
  assign w_edge = w_rise | w_fall;

  // An edge in the same cycle as the timeout wins over the timeout
  assign w_timeout = en & ~w_edge & (r_icnt == c_timeout_last);

  assign w_pass = (r_wcnt >= c_min_width)  && (r_wcnt <= c_max_width) &&
                  (r_pcnt >= c_min_period) && (r_pcnt <= c_max_period);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pcnt_nxt  = r_pcnt;
    w_check     = 1'b0;

    // Idle counter saturates at the timeout so LOST is raised only once
    if (w_edge) begin
      w_icnt_nxt = '0;
    end else if (r_icnt != c_timeout) begin
      w_icnt_nxt = r_icnt + c_one;
    end else begin
      w_icnt_nxt = r_icnt;
    end

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_wcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
      w_icnt_nxt  = '0;
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_wcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_HIGH;
            w_wcnt_nxt  = c_one;
            w_pcnt_nxt  = c_one;
          end
        end
        S_HIGH: begin
          w_pcnt_nxt = r_pcnt + c_one;
          if (w_fall) begin
            w_state_nxt = S_LOW;
          end else begin
            w_wcnt_nxt = r_wcnt + c_one;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_check     = 1'b1;
            w_state_nxt = S_HIGH;
            w_wcnt_nxt  = c_one;
            w_pcnt_nxt  = c_one;
          end else begin
            w_pcnt_nxt = r_pcnt + c_one;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
          w_pcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
      r_icnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_icnt  <= w_icnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_width <= '0;
      period      <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      lost        <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (w_check) begin
        if (w_pass) begin
          pulse_width <= r_wcnt;
          period      <= r_pcnt;
          valid       <= 1'b1;
          lost        <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (w_timeout) begin
        lost <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_servo_pwm_decoder
// Brief    : Directed bench for servo_pwm_decoder with an event scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_servo_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pwm_in;
  logic [31:0] pulse_width;
  logic [31:0] period;
  logic        valid;
  logic        err;
  logic        lost;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] pw;
    logic [31:0] per;
  } ev_t;

  ev_t sb[$];

  servo_pwm_decoder #(
    .CNT_W      (32),
    .MIN_WIDTH  (5),
    .MAX_WIDTH  (20),
    .MIN_PERIOD (50),
    .MAX_PERIOD (100),
    .TIMEOUT    (150)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pwm_in      (pwm_in),
    .pulse_width (pulse_width),
    .period      (period),
    .valid       (valid),
    .err         (err),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [31:0] pw, input logic [31:0] per);
    ev_t e;
    e.is_err = is_err;
    e.pw     = pw;
    e.per    = per;
    sb.push_back(e);
  endtask

  // High for h cycles then low for l cycles, changes on falling clock edges
  task automatic pulse(input int h, input int l);
    @(negedge clk) pwm_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk) pwm_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  // Every VALID or ERR strobe must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (valid === 1'b1 || err === 1'b1)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed valid=%0d err=%0d expected none", valid, err);
      end
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        chk("sb_valid", {31'd0, valid}, {31'd0, ~e.is_err});
        chk("sb_err", {31'd0, err}, {31'd0, e.is_err});
        chk("sb_pulse_width", pulse_width, e.pw);
        chk("sb_period", period, e.per);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse_width", pulse_width, 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lost", {31'd0, lost}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 10/70 train: first rise only starts a measurement
    pulse(10, 70);
    push(1'b0, 32'd10, 32'd80);
    @(negedge clk) pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("valid_before_lat", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("valid_lat3", {31'd0, valid}, 32'd1);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, valid}, 32'd0);
    repeat (5) @(negedge clk);
    @(negedge clk) pwm_in = 1'b0;
    repeat (69) @(negedge clk);
    chk("c1_pulse_width", pulse_width, 32'd10);
    chk("c1_period", period, 32'd80);
    push(1'b0, 32'd10, 32'd80);
    pulse(10, 70);

    // Short 3-cycle pulse fails the width check on the following rise
    push(1'b0, 32'd10, 32'd80);
    pulse(3, 77);
    push(1'b1, 32'd10, 32'd80);

    // 10 high then 200 low: LOST after TIMEOUT idle cycles from the fall
    @(negedge clk) pwm_in = 1'b1;
    repeat (9) @(negedge clk);
    @(negedge clk) pwm_in = 1'b0;
    chk("c2_pulse_width_held", pulse_width, 32'd10);
    chk("c2_period_held", period, 32'd80);
    repeat (152) @(negedge clk);
    chk("lost_before_timeout", {31'd0, lost}, 32'd0);
    @(negedge clk);
    chk("lost_at_timeout", {31'd0, lost}, 32'd1);
    repeat (46) @(negedge clk);

    // Resume: first rise from IDLE does not measure, second one does
    pulse(10, 70);
    chk("lost_held", {31'd0, lost}, 32'd1);
    push(1'b0, 32'd10, 32'd80);
    pulse(10, 70);
    chk("lost_cleared", {31'd0, lost}, 32'd0);

    // Stuck high: this rise closes a good period, then the line freezes
    push(1'b0, 32'd10, 32'd80);
    @(negedge clk) pwm_in = 1'b1;
    repeat (152) @(negedge clk);
    chk("stuck_lost_before", {31'd0, lost}, 32'd0);
    @(negedge clk);
    chk("stuck_lost_at", {31'd0, lost}, 32'd1);
    repeat (46) @(negedge clk);
    @(negedge clk) pwm_in = 1'b0;
    repeat (69) @(negedge clk);

    // Enable dropped during a high phase discards that measurement
    pulse(10, 70);
    push(1'b0, 32'd10, 32'd80);
    @(negedge clk) pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk) en = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk) en = 1'b1;
    @(negedge clk) pwm_in = 1'b0;
    repeat (69) @(negedge clk);
    chk("en_lost", {31'd0, lost}, 32'd0);
    pulse(10, 70);
    push(1'b0, 32'd10, 32'd80);

    // Asynchronous reset in the middle of a low phase
    @(negedge clk) pwm_in = 1'b1;
    repeat (9) @(negedge clk);
    @(negedge clk) pwm_in = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_pulse_width", pulse_width, 32'd10);
    chk("pre_rst_period", period, 32'd80);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("arst_pulse_width", pulse_width, 32'd0);
    chk("arst_period", period, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_lost", {31'd0, lost}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pulse(10, 70);
    chk("post_rst_no_update", pulse_width, 32'd0);
    push(1'b0, 32'd10, 32'd80);
    pulse(10, 70);

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
